data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's memory-visit stage data port (memwriteM, aluoutM, writedata2M, selM, readdataM).
- Converts that single-cycle access into a one-outstanding SRAM-like req/addr_ok/data_ok bus transaction.
- Drives a stall back to the pipeline for the length of the bus transaction and holds load data until the pipeline advances.

Parameters:
- ADDR_W, 32, width of core and bus address.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- mem_enM  input  1  M-stage load or store present.
- memwriteM  input  1  1=store, 0=load.
- aluoutM  input  ADDR_W  byte address.
- writedata2M  input  DATA_W  store data, already lane-aligned.
- selM  input  4  byte enables.
- hold_i  input  1  pipeline held by another source (e.g. divider).
- flush_i  input  1  M-stage instruction cancelled (exception).
- readdataM  output  DATA_W  load data to core.
- stallM  output  1  stall request to hazard unit.
- data_req  output  1  bus request.
- data_wr  output  1  bus write.
- data_size  output  2  0=byte, 1=half, 2=word.
- data_addr  output  ADDR_W  bus address.
- data_wdata  output  DATA_W  bus write data.
- data_addr_ok  input  1  address accepted.
- data_data_ok  input  1  data returned / write complete.
- data_rdata  input  DATA_W  bus read data.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, readdataM=0, cancel flag=0. Reset mid-transaction abandons it; any later data_ok is ignored until a new request is issued.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If mem_enM=1 and flush_i=0: register wr, size, addr, wdata; go ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - data_req=1 with registered fields held stable.
  - On addr_ok, go DATA; data_req drops the following cycle.
  - req is never withdrawn before addr_ok.
- DATA:
  - Wait for data_ok. On data_ok, latch data_rdata into readdataM (loads only; stores leave it unchanged).
  - Go DONE, or go IDLE if the cancel flag is set.
  - data_ok seen in ADDR is ignored; the bus never returns data_ok in the same cycle as addr_ok.
- DONE:
  - stallM=0, readdataM stable.
  - If hold_i=1, stay in DONE with no new request; otherwise go IDLE.
  - A new access is therefore issued no earlier than the cycle after DONE.
- stallM (combinational) = mem_enM & ~flush_i & (state!=DONE), OR (state!=IDLE & state!=DONE).
  - Minimum stall for any access: 3 cycles (IDLE→ADDR→DATA→DONE with addr_ok and data_ok at their earliest).
- data_size from selM:
  - 4'b1111 → 2.
  - 4'b0011 or 4'b1100 → 1.
  - One-hot → 0.
  - Any other pattern → 2.
- data_addr = aluoutM unmodified; the low bits are kept.
- flush_i:
  - In IDLE: no request is issued.
  - In ADDR/DATA: sets the cancel flag. The transaction drains to data_ok, then FSM returns to IDLE, readdataM is unchanged, and the flag clears.
  - flush_i has no effect in DONE.
- mem_enM=0 in IDLE: stallM=0, bus idle.

Optional Feature:
- Macro: DATA_SRAM_BRIDGE_KSEG_EN.
- Defined: addresses in 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) have bits [31:29] cleared on data_addr. Example: 0xBFC0_0010 → 0x1FC0_0010. Other addresses pass unchanged.
- Undefined: data_addr = aluoutM always.

Test Plan:
- Load word, addr 0x0000_0040, sel 1111, addr_ok after 2 cycles, data_ok 1 cycle later with rdata 0xDEAD_BEEF → one req with size 2; stallM high for 4 cycles; readdataM=0xDEAD_BEEF in DONE.
- Store byte, addr 0x0000_0043, sel 1000, wdata 0x7700_0000 → data_wr=1, size 0, addr 0x43; readdataM unchanged; stall clears after data_ok.
- Flush in DATA state of a load, data_ok rdata 0x1234_5678 → FSM returns to IDLE; readdataM keeps its old value; no DONE cycle.
- hold_i=1 for 3 cycles in DONE after load 0xCAFE_0001 → readdataM stable, stallM=0, data_req=0 throughout; IDLE on the first cycle with hold_i=0.
- rst=0 while in ADDR → next cycle state IDLE, data_req=0; a stray data_ok afterwards leaves readdataM=0.
- With DATA_SRAM_BRIDGE_KSEG_EN: load at 0x8000_1000 → data_addr=0x0000_1000. Without the macro → data_addr=0x8000_1000.

Source files
------------

// File: rtl/data_sram_bridge.sv
// Bridges the M-stage single-cycle data port onto a one-outstanding SRAM-like req/addr_ok/data_ok bus.
// Optional: define DATA_SRAM_BRIDGE_KSEG_EN to strip bits [31:29] from kseg0/kseg1 addresses.
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enM,
    input  logic              memwriteM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedata2M,
    input  logic [3:0]        selM,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

    stateT state;
    logic  cancel;

    function automatic logic [1:0] sizeFromSel(input logic [3:0] sel);
        case (sel)
            4'b1111:                            return 2'd2;
            4'b0011, 4'b1100:                   return 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            default:                            return 2'd2;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] mapAddr(input logic [ADDR_W-1:0] addr);
`ifdef DATA_SRAM_BRIDGE_KSEG_EN
        logic [ADDR_W-1:0] mapped;
        mapped = addr;
        if (addr[ADDR_W-1 -: 2] == 2'b10)
            mapped[ADDR_W-1 -: 3] = 3'b000;
        return mapped;
`else
        return addr;
`endif
    endfunction

    // The stall covers the launching IDLE cycle plus every cycle the bus transaction is open.
    assign stallM = (mem_enM & ~flush_i & (state != DONE)) |
                    ((state != IDLE) & (state != DONE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            readdataM  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_enM && !flush_i) begin
                        data_req   <= 1'b1;
                        data_wr    <= memwriteM;
                        data_size  <= sizeFromSel(selM);
                        data_addr  <= mapAddr(aluoutM);
                        data_wdata <= writedata2M;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (flush_i)
                        cancel <= 1'b1;
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // A cancelled access still drains its data_ok but never reaches the core.
                    if (data_data_ok) begin
                        if (cancel || flush_i) begin
                            cancel <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            if (!data_wr)
                                readdataM <= data_rdata;
                            state <= DONE;
                        end
                    end else if (flush_i) begin
                        cancel <= 1'b1;
                    end
                end
                DONE: begin
                    if (!hold_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: a timeline-based model predicts outputs for each access.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_enM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedata2M;
    logic [3:0]  selM;
    logic        hold_i;
    logic        flush_i;
    logic [31:0] readdataM;
    logic        stallM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_enM(mem_enM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedata2M(writedata2M), .selM(selM),
        .hold_i(hold_i), .flush_i(flush_i), .readdataM(readdataM), .stallM(stallM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Model outputs for the current cycle
    logic        chkOn = 1'b0;
    logic        chkBus = 1'b0;
    logic        expStall, expReq, expWr;
    logic [1:0]  expSize;
    logic [31:0] expAddr, expWdata;
    logic [31:0] mdlRdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sizeOf(input logic [3:0] sel);
        if (sel == 4'hF) return 2'd2;
        if (sel == 4'h3 || sel == 4'hC) return 2'd1;
        if ($countones(sel) == 1) return 2'd0;
        return 2'd2;
    endfunction

    function automatic logic [31:0] busAddr(input logic [31:0] a);
`ifdef DATA_SRAM_BRIDGE_KSEG_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    task automatic idleInputs();
        mem_enM = 0; memwriteM = 0; aluoutM = 0; writedata2M = 0; selM = 0;
        hold_i = 0; flush_i = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    // Cycle 0 launches from IDLE; addr_ok lands aWait cycles after req rises, data_ok dWait cycles
    // after the DATA phase starts, so the first non-stalled (DONE) cycle is T = 3 + aWait + dWait.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int aWait, input int dWait, input int flushAt, input int holdCyc);
        int T, last;
        bit flushed;
        T       = 3 + aWait + dWait;
        flushed = (flushAt >= 1) && (flushAt <= T - 1);
        last    = flushed ? T : T + holdCyc;
        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clk); #1;
            mem_enM      = (k <= last) && !(flushed && k >= flushAt);
            memwriteM    = wr;
            aluoutM      = addr;
            selM         = sel;
            writedata2M  = wdata;
            flush_i      = (k == flushAt);
            hold_i       = !flushed && k >= T && k < T + holdCyc;
            data_addr_ok = (k == 1 + aWait);
            data_data_ok = (k == 2 + aWait + dWait);
            data_rdata   = data_data_ok ? rdata : ~rdata;
            expStall     = (k <= T - 1);
            expReq       = (k >= 1) && (k <= 1 + aWait);
            if (k == T && !wr && !flushed) mdlRdata = rdata;
            chkBus   = expReq;
            expWr    = wr;
            expSize  = sizeOf(sel);
            expAddr  = busAddr(addr);
            expWdata = wdata;
        end
        idleInputs();
        chkBus = 1'b0;
    endtask

    task automatic driver();
        // Reset state
        rst = 0; idleInputs();
        @(posedge clk); #1;
        expStall = 0; expReq = 0; mdlRdata = 0;
        chkBus = 1; expWr = 0; expSize = 0; expAddr = 0; expWdata = 0;
        chkOn = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chkBus = 0;

        // Load word, addr_ok after 2 req cycles, data_ok one cycle later
        access(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 0, -1, 0);
        check("lit_load_word", mdlRdata, 32'hDEAD_BEEF);
        // Store byte
        access(1'b1, 32'h0000_0043, 4'b1000, 32'h7700_0000, 32'hFFFF_0000, 0, 1, -1, 0);
        check("lit_size_byte", {30'b0, sizeOf(4'b1000)}, 32'd0);
        // Store half at minimum latency
        access(1'b1, 32'h0000_0010, 4'b0011, 32'h0000_BEAD, 32'h0, 0, 0, -1, 0);
        // Non-standard enable pattern falls back to word
        access(1'b0, 32'h0000_0020, 4'b0101, 32'h0, 32'h0102_0304, 2, 2, -1, 0);
        // Flush while in DATA: drains to data_ok, load data discarded
        access(1'b0, 32'h0000_0080, 4'b1111, 32'h0, 32'h1234_5678, 0, 2, 3, 0);
        check("lit_flush_keep", mdlRdata, 32'h0102_0304);
        // Held in DONE for three cycles
        access(1'b0, 32'h0000_0084, 4'b1111, 32'h0, 32'hCAFE_0001, 0, 0, -1, 3);
        check("lit_hold_load", mdlRdata, 32'hCAFE_0001);
        // Flush in IDLE: no request
        @(posedge clk); #1;
        mem_enM = 1; aluoutM = 32'h0000_0090; selM = 4'hF; flush_i = 1;
        expStall = 0; expReq = 0;
        @(posedge clk); #1;
        idleInputs();
        @(posedge clk); #1;
        // kseg addresses
        access(1'b0, 32'h8000_1000, 4'b1111, 32'h0, 32'hA5A5_0000, 0, 0, -1, 0);
        access(1'b1, 32'hBFC0_0010, 4'b1100, 32'hABCD_0000, 32'h0, 1, 0, -1, 0);
        access(1'b0, 32'hC000_0004, 4'b0100, 32'h0, 32'h0000_5A00, 0, 0, -1, 0);
`ifdef DATA_SRAM_BRIDGE_KSEG_EN
        check("lit_kseg_addr", busAddr(32'h8000_1000), 32'h0000_1000);
`else
        check("lit_kseg_addr", busAddr(32'h8000_1000), 32'h8000_1000);
`endif
        // Reset while in ADDR, then a stray data_ok
        @(posedge clk); #1;
        mem_enM = 1; aluoutM = 32'h0000_0100; selM = 4'hF;
        expStall = 1; expReq = 0;
        @(posedge clk); #1;
        rst = 0; expStall = 1; expReq = 1;
        chkBus = 1; expWr = 0; expSize = 2; expAddr = 32'h0000_0100; expWdata = 0;
        @(posedge clk); #1;
        rst = 1; mem_enM = 0;
        expStall = 0; expReq = 0; mdlRdata = 0;
        expWr = 0; expSize = 0; expAddr = 0; expWdata = 0;
        @(posedge clk); #1;
        data_data_ok = 1; data_rdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        idleInputs();
        @(posedge clk); #1;
        check("lit_rst_rdata", mdlRdata, 32'h0);
        chkOn = 0;
    endtask

    task automatic compare();
        forever begin
            @(negedge clk);
            if (chkOn) begin
                check("stallM", {31'b0, stallM}, {31'b0, expStall});
                check("data_req", {31'b0, data_req}, {31'b0, expReq});
                check("readdataM", readdataM, mdlRdata);
                if (chkBus) begin
                    check("data_wr", {31'b0, data_wr}, {31'b0, expWr});
                    check("data_size", {30'b0, data_size}, {30'b0, expSize});
                    check("data_addr", data_addr, expAddr);
                    check("data_wdata", data_wdata, expWdata);
                end
            end
        end
    endtask

    initial begin
        fork
            driver();
            compare();
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
